// File: rtl/clock_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// Optional duty measurement is enabled by defining DUTY_MEASURE_EN.
package clock_meter_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 1 << 20;

    typedef enum logic [1:0] {
        S_ARM,
        S_COUNT,
        S_STALL
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input plus a delay
// register, producing the synchronised level and a one-cycle rise strobe.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_sig;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures rise-to-rise period (and high time with DUTY_MEASURE_EN)
// of a periodic input in clk cycles; flags a stall after TIMEOUT cycles.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic w_sync;
    logic w_rise;

    sync_edge_detect u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (sig_in),
        .o_sync (w_sync),
        .o_rise (w_rise)
    );

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_stalled;
    logic             w_reload;
    logic             w_inc;
    logic             w_report;
    logic             w_stall_set;
    logic             w_stall_clr;

    // Every rise reloads the counters; only a rise in S_COUNT reports.
    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        w_inc       = 1'b0;
        w_report    = 1'b0;
        w_stall_set = 1'b0;
        w_stall_clr = 1'b0;
        unique case (r_state)
            S_ARM: begin
                if (w_rise) begin
                    w_reload    = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_rise) begin
                    w_reload = 1'b1;
                    w_report = 1'b1;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_stall_set = 1'b1;
                    w_state_nxt = S_STALL;
                end else begin
                    w_inc = 1'b1;
                end
            end
            S_STALL: begin
                if (w_rise) begin
                    w_reload    = 1'b1;
                    w_stall_clr = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            default: w_state_nxt = S_ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (w_report) begin
                r_period <= r_cnt;
            end
            if (w_reload) begin
                r_cnt <= C_ONE;
            end else if (w_inc) begin
                r_cnt <= r_cnt + C_ONE;
            end
            if (w_stall_set) begin
                r_stalled <= 1'b1;
            end else if (w_stall_clr) begin
                r_stalled <= 1'b0;
            end
        end
    end

`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_high_time;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt      <= '0;
            r_high_time <= '0;
        end else begin
            if (w_report) begin
                r_high_time <= r_hcnt;
            end
            if (w_reload) begin
                r_hcnt <= C_ONE;
            end else if (w_inc) begin
                r_hcnt <= r_hcnt + CNT_W'(w_sync);
            end
        end
    end

    assign high_time = r_high_time;
`else
    logic w_unused_sync;
    assign w_unused_sync = w_sync;
    assign high_time     = '0;
`endif

    assign period  = r_period;
    assign valid   = r_valid;
    assign stalled = r_stalled;

endmodule
